// File: rtl/bit_stuff_pkg.sv
// Shared types for the serial bit stuffer: FSM states,
// run-counter width and the FIFO entry layout.
package bit_stuff_pkg;

    localparam int RUN_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STUFF
    } state_t;

    typedef struct packed {
        logic last;
        logic data;
    } fifo_entry_t;

endpackage

// File: rtl/stuff_fifo.sv
// DEPTH x {last,data} synchronous FIFO with full/empty/count,
// asynchronous active-low reset of pointers and count.
module stuff_fifo
    import bit_stuff_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  fifo_entry_t            i_entry,
    input  logic                   i_pop,
    output fifo_entry_t            o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bit_stuff_stream.sv
// Serial bit stuffer: inserts ~MATCH_BIT after RUN_LEN equal bits,
// valid/ready on both sides, per-frame stuff count report.
module bit_stuff_stream
    import bit_stuff_pkg::*;
#(
    parameter int   DEPTH        = 8,
    parameter int   RUN_LEN      = 5,
    parameter logic MATCH_BIT    = 1'b1,
    parameter bit   STUFF_AT_END = 1'b1,
    parameter int   CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_data,
    output logic             out_last,
    output logic [CNT_W-1:0] frame_stuffs,
    output logic             frame_done
);

    localparam int AW = $clog2(DEPTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_out_data;
    logic             r_out_last;
    logic             r_stuff_last;
    logic             r_frame_done;
    logic [RUN_W-1:0] r_run;
    logic [CNT_W-1:0] r_stuff_cnt;
    logic [CNT_W-1:0] r_frame_stuffs;

    fifo_entry_t      w_head;
    fifo_entry_t      w_in_entry;
    logic             w_full;
    logic             w_empty;
    logic [AW:0]      w_count;
    logic [AW:0]      w_cnt_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_load;
    logic             w_ld_data;
    logic             w_ld_stuff;
    logic             w_match;
    logic             w_stuff_hit;
    logic             w_beat_last;
    logic             w_out_valid_nxt;
    logic             w_out_data_nxt;
    logic             w_out_last_nxt;
    logic             w_stuff_last_nxt;
    logic [RUN_W-1:0] w_run_nxt;

    assign w_in_entry  = '{last: in_last, data: in_data};
    assign w_push      = in_valid && r_in_ready && !w_full;
    assign w_load      = !r_out_valid || out_ready;
    assign w_beat_last = r_out_valid && out_ready && r_out_last;
    assign w_match     = (w_head.data == MATCH_BIT);
    assign w_cnt_nxt   = w_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

    // A run ending on the frame's last bit stuffs only with STUFF_AT_END.
    assign w_stuff_hit = w_match
                      && (r_run + RUN_W'(1) == RUN_W'(RUN_LEN))
                      && (STUFF_AT_END || !w_head.last);

    stuff_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_entry (w_in_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_ld_data   = 1'b0;
        w_ld_stuff  = 1'b0;
        if (w_load) begin
            unique case (r_state)
                STUFF: begin
                    w_ld_stuff  = 1'b1;
                    w_state_nxt = w_empty ? IDLE : DATA;
                end
                default: begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_ld_data   = 1'b1;
                        w_state_nxt = w_stuff_hit ? STUFF : DATA;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            endcase
        end
    end

    // The stuff decision is known at pop time, so last moves with it.
    always_comb begin
        w_out_valid_nxt  = r_out_valid;
        w_out_data_nxt   = r_out_data;
        w_out_last_nxt   = r_out_last;
        w_stuff_last_nxt = r_stuff_last;
        w_run_nxt        = r_run;
        if (w_ld_stuff) begin
            w_out_valid_nxt  = 1'b1;
            w_out_data_nxt   = ~MATCH_BIT;
            w_out_last_nxt   = r_stuff_last;
            w_stuff_last_nxt = 1'b0;
            w_run_nxt        = '0;
        end else if (w_ld_data) begin
            w_out_valid_nxt  = 1'b1;
            w_out_data_nxt   = w_head.data;
            w_out_last_nxt   = w_head.last && !w_stuff_hit;
            w_stuff_last_nxt = w_head.last && w_stuff_hit;
            if (w_head.last || !w_match) begin
                w_run_nxt = '0;
            end else begin
                w_run_nxt = r_run + RUN_W'(1);
            end
        end else if (w_load) begin
            w_out_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready     <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_data     <= 1'b0;
            r_out_last     <= 1'b0;
            r_stuff_last   <= 1'b0;
            r_run          <= '0;
            r_stuff_cnt    <= '0;
            r_frame_stuffs <= '0;
            r_frame_done   <= 1'b0;
        end else begin
            r_in_ready   <= (w_cnt_nxt < (AW+1)'(DEPTH));
            r_out_valid  <= w_out_valid_nxt;
            r_out_data   <= w_out_data_nxt;
            r_out_last   <= w_out_last_nxt;
            r_stuff_last <= w_stuff_last_nxt;
            r_run        <= w_run_nxt;
            r_frame_done <= w_beat_last;
            if (w_beat_last) begin
                r_frame_stuffs <= r_stuff_cnt;
                r_stuff_cnt    <= '0;
            end else if (w_ld_stuff && (r_stuff_cnt != '1)) begin
                r_stuff_cnt <= r_stuff_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_last     = r_out_last;
    assign frame_stuffs = r_frame_stuffs;
    assign frame_done   = r_frame_done;

endmodule
